// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, NOP encoding and prefetch entry type for the fetch unit.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch FIFO; flush wins over enq and deq.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t enq_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head_entry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_enq, do_deq;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_entry = mem_q[rd_ptr_q];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_enq = enq & (~full | deq);
  assign do_deq = deq & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) begin
        mem_d[wr_ptr_q] = enq_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencer feeding the prefetch FIFO from a combinational ROM.
// Define FETCH_FAULT_EN to tag out-of-range and misaligned-redirect fetches as faults.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h00000000,
  parameter int                DEPTH     = 2,
  parameter int                ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_fault
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              full, empty;
  logic              enq, deq;
  fetch_entry_t      wr_entry, head_entry;

  assign rom_addr  = pc_q;
  assign out_valid = ~empty;
  assign deq       = out_valid & out_ready;
  assign enq       = ~redirect_valid & (~full | deq);
  assign out_inst  = head_entry.inst;
  assign out_pc    = head_entry.pc;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (enq) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_FAULT_EN
  localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_WORDS * 4);

  logic misalign_q, misalign_d;
  logic fault;

  // The misalignment flag marks only the first word fetched after the redirect that caused it.
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) begin
      misalign_d = |redirect_pc[1:0];
    end else if (enq) begin
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fault          = (pc_q >= ROM_LIMIT) | misalign_q;
  assign wr_entry.inst  = fault ? NOP_INST : rom_data;
  assign wr_entry.pc    = pc_q;
  assign wr_entry.fault = fault;
  assign out_fault      = head_entry.fault;
`else
  logic unused_bits;

  assign wr_entry.inst  = rom_data;
  assign wr_entry.pc    = pc_q;
  assign wr_entry.fault = 1'b0;
  assign out_fault      = 1'b0;
  assign unused_bits    = ^{redirect_pc[1:0], head_entry.fault, (ROM_WORDS > 0)};
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq        (enq),
    .deq        (deq),
    .flush      (redirect_valid),
    .enq_entry  (wr_entry),
    .full       (full),
    .empty      (empty),
    .head_entry (head_entry)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed plus randomized bench for fetch_ctrl against a queue-based model.
module tb_fetch_ctrl;

`ifdef FETCH_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rom_mem [64];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_pc;
  logic        m_mis;

  always #5 clk = ~clk;

  always_comb rom_data = (rom_addr < 32'd256) ? rom_mem[rom_addr[7:2]] : (rom_addr ^ 32'hA5A50000);

  fetch_ctrl #(
    .RESET_PC  (32'h00000000),
    .DEPTH     (DEPTH),
    .ROM_WORDS (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a < 32'd256) ? rom_mem[a[7:2]] : (a ^ 32'hA5A50000);
  endfunction

  function automatic exp_t make_entry(input logic [31:0] pc, input logic mis);
    exp_t e;
    e.pc    = pc;
    e.fault = FAULT_EN && ((pc >= 32'd256) || mis);
    e.inst  = e.fault ? 32'h00000013 : rom_word(pc);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
    if (rv) begin
      mq.delete();
      m_pc  = {rpc[31:2], 2'b00};
      m_mis = (rpc[1:0] != 2'b00);
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back(make_entry(m_pc, m_mis));
        m_pc  = m_pc + 32'd4;
        m_mis = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    check("model_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    check("model_rom_addr", rom_addr, m_pc);
    if (mq.size() != 0) begin
      check("model_pc", out_pc, mq[0].pc);
      check("model_inst", out_inst, mq[0].inst);
      check("model_fault", {31'b0, out_fault}, {31'b0, mq[0].fault});
    end
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_step(rdy, rv, rpc);
    #1;
    check_model();
  endtask

  // Asserts reset away from any clock edge and checks the outputs before the next edge.
  task automatic do_reset();
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    mq.delete();
    m_pc  = 32'h0;
    m_mis = 1'b0;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_rom_addr", rom_addr, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_fault", {31'b0, out_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("stream_pc", out_pc, 32'(4 * i));
      check("stream_lead", rom_addr, out_pc + 32'd4);
    end

    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    check("bp_rom_addr", rom_addr, 32'h8);
    check("bp_valid", {31'b0, out_valid}, 32'h1);
    check("bp_pc", out_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_drain_pc", out_pc, 32'(4 * i));
      cycle(1'b1, 1'b0, 32'h0);
    end

    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h14);
    check("redir_gap", {31'b0, out_valid}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir_pc0", out_pc, 32'h14);
    cycle(1'b1, 1'b0, 32'h0);
    check("redir_pc1", out_pc, 32'h18);

    cycle(1'b1, 1'b1, 32'h17);
    cycle(1'b1, 1'b0, 32'h0);
    check("mis_pc", out_pc, 32'h14);
    check("mis_fault", {31'b0, out_fault}, {31'b0, FAULT_EN});
    check("mis_inst", out_inst, FAULT_EN ? 32'h00000013 : rom_mem[5]);
    cycle(1'b1, 1'b0, 32'h0);
    check("mis_next_fault", {31'b0, out_fault}, 32'h0);

    cycle(1'b1, 1'b1, 32'hFFFFFFFC);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc0", out_pc, 32'hFFFFFFFC);
    check("wrap_fault0", {31'b0, out_fault}, {31'b0, FAULT_EN});
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc1", out_pc, 32'h0);
    check("wrap_fault1", {31'b0, out_fault}, 32'h0);

    cycle(1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b0, 32'h0);
    check("range_pc", out_pc, 32'h100);
    check("range_fault", {31'b0, out_fault}, {31'b0, FAULT_EN});

    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    check("mid_full_valid", {31'b0, out_valid}, 32'h1);
    #2;
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    check("restart_pc", out_pc, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom_range(0, 255);
        1:       rpc = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      cycle(rdy, rv, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
